// File: rtl/sensor_conditioner.sv
// Loop-detector conditioning for a two-street intersection: synchronize,
// debounce, hold off short dropouts, and count qualified arrivals per street.

// One street's conditioning channel: synchronizer, presence FSM, arrival count.
module sensor_channel #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    input  logic       clear_cnt,
    output logic       sensor,
    output logic       arrival,
    output logic [7:0] count
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(255);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t        state;
    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] hold_cnt;

    // Two-flop synchronizer for the asynchronous loop level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Presence FSM; sensor tracks PRESENT/HOLD, arrival and count update on qualification.
    // The dropout counter releases on the HOLD_CYCLES-th consecutive low sample,
    // mirroring how the debounce counter qualifies on the DEB_CYCLES-th high one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            sensor   <= 1'b0;
            arrival  <= 1'b0;
            count    <= '0;
        end else begin
            arrival <= 1'b0;
            if (clear_cnt) begin
                count <= '0;
            end
            case (state)
                IDLE: begin
                    if (sync_2) begin
                        state   <= QUAL;
                        deb_cnt <= CW'(1);
                    end
                end
                QUAL: begin
                    if (!sync_2) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= PRESENT;
                        sensor  <= 1'b1;
                        arrival <= 1'b1;
                        if (clear_cnt) begin
                            count <= CW'(1);
                        end else if (count != CNT_MAX) begin
                            count <= count + CW'(1);
                        end
                    end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                    end
                end
                PRESENT: begin
                    if (!sync_2) begin
                        if (HOLD_CYCLES == 1) begin
                            state  <= IDLE;
                            sensor <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (sync_2) begin
                        state <= PRESENT;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state  <= IDLE;
                        sensor <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    sensor <= 1'b0;
                end
            endcase
        end
    end

endmodule

// Top level: two independent, identical street channels sharing clock, reset and count clear.
module sensor_conditioner #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_A,
    input  logic       raw_B,
    input  logic       clear_cnt,
    output logic       sensor_A,
    output logic       sensor_B,
    output logic       arrival_A,
    output logic       arrival_B,
    output logic [7:0] count_A,
    output logic [7:0] count_B
);

    sensor_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw_A),
        .clear_cnt(clear_cnt),
        .sensor   (sensor_A),
        .arrival  (arrival_A),
        .count    (count_A)
    );

    sensor_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw_B),
        .clear_cnt(clear_cnt),
        .sensor   (sensor_B),
        .arrival  (arrival_B),
        .count    (count_B)
    );

endmodule
